// File: rtl/seq_divider_if.sv
// Start/ready/done handshake and operand/result bus for the iterative divider.
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic             flush_i;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             ready_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;

   modport master (
      output start_i, flush_i, op_i, dividend_i, divisor_i,
      input  ready_o, done_o, result_o
   );

   modport slave (
      input  start_i, flush_i, op_i, dividend_i, divisor_i,
      output ready_o, done_o, result_o
   );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIVIDER_EARLY_OUT_EN: divide-by-zero, overflow and |a|<|b| finish straight from IDLE.
//
// state | meaning
// IDLE  | ready for a new operation
// CALC  | one shift/subtract step per cycle, WIDTH steps
// FIX   | sign correction and result select, result_o written
// DONE  | done_o high for this single cycle
module seq_divider #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   seq_divider_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dsr;
   logic [CNT_W-1:0] cnt;
   logic             is_rem;
   logic             neg_quo;
   logic             neg_rem;
   logic             div_zero;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;

   logic             signed_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_diff;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   always_comb begin
      signed_op = ~bus.op_i[0];
      a_neg     = signed_op & bus.dividend_i[WIDTH-1];
      b_neg     = signed_op & bus.divisor_i[WIDTH-1];
      abs_a     = a_neg ? -bus.dividend_i : bus.dividend_i;
      abs_b     = b_neg ? -bus.divisor_i : bus.divisor_i;
      rem_sh    = {rem, quo[WIDTH-1]};
      rem_ge    = rem_sh >= {1'b0, dsr};
      // The true difference always fits in WIDTH bits when rem_ge holds.
      rem_diff  = rem_sh[WIDTH-1:0] - dsr;
      // With a zero divisor the magnitude path leaves |dividend| in rem, so re-signing it restores the raw dividend.
      q_fix     = div_zero ? '1 : (neg_quo ? -quo : quo);
      r_fix     = neg_rem ? -rem : rem;
   end

`ifdef DIVIDER_EARLY_OUT_EN
   logic             eo_zero;
   logic             eo_ovf;
   logic             eo_small;
   logic             eo_hit;
   logic [WIDTH-1:0] eo_result;

   always_comb begin
      eo_zero  = bus.divisor_i == '0;
      eo_ovf   = signed_op && (bus.dividend_i == MIN_NEG) && (bus.divisor_i == '1);
      eo_small = abs_a < abs_b;
      eo_hit   = eo_zero | eo_ovf | eo_small;
      if (eo_zero)
         eo_result = bus.op_i[1] ? bus.dividend_i : '1;
      else if (eo_ovf)
         eo_result = bus.op_i[1] ? '0 : MIN_NEG;
      else
         eo_result = bus.op_i[1] ? bus.dividend_i : '0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rem      <= '0;
         quo      <= '0;
         dsr      <= '0;
         cnt      <= '0;
         is_rem   <= 1'b0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         ready    <= 1'b1;
         done     <= 1'b0;
         result   <= '0;
      end else if (bus.flush_i) begin
         state <= IDLE;
         ready <= 1'b1;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (bus.start_i) begin
                  is_rem   <= bus.op_i[1];
                  neg_quo  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= bus.divisor_i == '0;
                  rem      <= '0;
                  quo      <= abs_a;
                  dsr      <= abs_b;
                  cnt      <= CNT_W'(WIDTH - 1);
                  ready    <= 1'b0;
`ifdef DIVIDER_EARLY_OUT_EN
                  if (eo_hit) begin
                     result <= eo_result;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     state <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               quo <= {quo[WIDTH-2:0], rem_ge};
               rem <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
               if (cnt == '0)
                  state <= FIX;
               else
                  cnt <= cnt - 1'b1;
            end
            FIX: begin
               result <= is_rem ? r_fix : q_fix;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready_o  = ready;
   assign bus.done_o   = done;
   assign bus.result_o = result;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed RV32M corner cases plus 1000 random ops
// checked against an arithmetic reference model; latency follows DIVIDER_EARLY_OUT_EN.
module tb_seq_divider;

   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] last_result = '0;
   logic        prev_done = 1'b0;

   seq_divider_if #(.WIDTH(32)) bus ();

   seq_divider #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // RV32M semantics written directly from the instruction definitions.
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      case (op)
         2'b00: begin
            if (b == 0) return '1;
            if (a == MIN_NEG && b == '1) return MIN_NEG;
            return 32'(sa / sb);
         end
         2'b01: return (b == 0) ? '1 : a / b;
         2'b10: begin
            if (b == 0) return a;
            if (a == MIN_NEG && b == '1) return '0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Edges from the accepting edge to the edge that raises done_o.
   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIVIDER_EARLY_OUT_EN
      logic [31:0] ma;
      logic [31:0] mb;
      ma = (!op[0] && a[31]) ? -a : a;
      mb = (!op[0] && b[31]) ? -b : b;
      if (b == 0 || (!op[0] && a == MIN_NEG && b == '1) || ma < mb) return 0;
`endif
      return 33;
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      int n = 0;
      while (!bus.ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.ready_o) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
         return;
      end
      bus.start_i    = 1'b1;
      bus.op_i       = op;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      exp_q.push_back('{res: exp, acc: cyc + 1, lat: exp_lat(op, a, b)});
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
      @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return '1;
         3: return MIN_NEG;
         4: return 32'($urandom_range(0, 255));
         default: return $urandom();
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         last_result = '0;
         prev_done   = 1'b0;
      end else begin
         if (bus.done_o) begin
            chk("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done actual=%h expected=no_done (cycle %0d)", bus.result_o, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("result", bus.result_o, e.res);
               chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
            last_result = bus.result_o;
         end else begin
            chk("result_hold", bus.result_o, last_result);
         end
         prev_done = bus.done_o;
      end
   end

   initial begin
      int          acc;
      logic [31:0] saved;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      bus.start_i    = 1'b0;
      bus.flush_i    = 1'b0;
      bus.op_i       = 2'b00;
      bus.dividend_i = '0;
      bus.divisor_i  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);
      chk("rst_done", {31'd0, bus.done_o}, 32'd0);
      chk("rst_result", bus.result_o, 32'd0);

      // DIVU 100/7 with the ready_o window
      do_op(2'b01, 32'd100, 32'd7, 32'd14);
      acc = cyc;
      chk("ready_low_e0", {31'd0, bus.ready_o}, 32'd0);
      repeat (33) @(negedge clk);
      chk("ready_low_done", {31'd0, bus.ready_o}, 32'd0);
      @(negedge clk);
      chk("ready_back", {31'd0, bus.ready_o}, 32'd1);
      chk("ready_edge", 32'(cyc - acc), 32'd34);
      drain();

      do_op(2'b11, 32'd100, 32'd7, 32'd2);
      do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      do_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
      do_op(2'b11, 32'd5, 32'd0, 32'd5);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
      do_op(2'b00, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG);
      do_op(2'b10, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
      do_op(2'b01, 32'd3, 32'd10, 32'd0);
      do_op(2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD);
      drain();

      // start pulsed mid-CALC is dropped
      do_op(2'b01, 32'd50, 32'd5, 32'd10);
      repeat (5) @(negedge clk);
      bus.start_i    = 1'b1;
      bus.op_i       = 2'b01;
      bus.dividend_i = 32'd1;
      bus.divisor_i  = 32'd1;
      @(negedge clk);
      bus.start_i = 1'b0;
      drain();
      repeat (40) @(negedge clk);

      // flush at CALC cycle 10
      saved = bus.result_o;
      do_op(2'b01, 32'd1000, 32'd3, 32'd333);
      repeat (9) @(negedge clk);
      bus.flush_i = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      bus.flush_i = 1'b0;
      chk("flush_ready", {31'd0, bus.ready_o}, 32'd1);
      chk("flush_result", bus.result_o, saved);
      repeat (40) @(negedge clk);
      do_op(2'b01, 32'd9, 32'd3, 32'd3);
      drain();

      // flush beats start in IDLE
      bus.start_i    = 1'b1;
      bus.flush_i    = 1'b1;
      bus.op_i       = 2'b01;
      bus.dividend_i = 32'd8;
      bus.divisor_i  = 32'd2;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      chk("flush_start_ready", {31'd0, bus.ready_o}, 32'd1);
      repeat (40) @(negedge clk);

      // asynchronous reset mid-CALC
      do_op(2'b01, 32'd77, 32'd7, 32'd11);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_ready", {31'd0, bus.ready_o}, 32'd1);
      chk("async_rst_done", {31'd0, bus.done_o}, 32'd0);
      chk("async_rst_result", bus.result_o, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 1000; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         do_op(op, a, b, ref_div(op, a, b));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
